// File: rtl/handshake_link_arbiter.sv
// handshake_link_arbiter: round-robin owner of one 4-phase req/ack link; define HS_TIMEOUT_EN for timeout abort
module handshake_link_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] send,
    input  logic               devB,
    output logic               devA,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic               busy,
    output logic               timeout_err,
    output logic               LED_send,
    output logic               LED_devB
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, REQ, REL, DONE, RECOVER} stateT;

    if (NUM_REQ < 2 || NUM_REQ > 8 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 4) begin : gBadParam
        $error("handshake_link_arbiter: parameter out of range");
    end

    logic [SYNC_STAGES-1:0][NUM_REQ-1:0] sendSync;
    logic [SYNC_STAGES-1:0]              devBSync;
    logic [NUM_REQ-1:0]                  sendS;
    logic                                devBS;
    stateT                               state, stateNext;
    logic [PW-1:0]                       ptr, owner, selIdx, ptrNext;
    logic                                selValid;

    assign sendS   = sendSync[SYNC_STAGES-1];
    assign devBS   = devBSync[SYNC_STAGES-1];
    assign ptrNext = owner == PW'(NUM_REQ - 1) ? '0 : owner + 1'b1;

    // Scan from the far end so the last hit is the one closest to ptr
    always_comb begin
        selValid = 1'b0;
        selIdx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (sendS[(int'(ptr) + i) % NUM_REQ]) begin
                selValid = 1'b1;
                selIdx   = PW'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

`ifdef HS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt;
    logic          timedOut;
    assign timedOut = cnt == CW'(TIMEOUT_CYCLES - 1);
    // Any state change restarts the count, so it is fresh on entry to REQ and REL
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            cnt <= stateNext == state ? cnt + 1'b1 : '0;
            if (stateNext == RECOVER) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sendSync <= '0;
            devBSync <= '0;
            state    <= IDLE;
            devA     <= 1'b0;
            grant    <= '0;
            owner    <= '0;
            ptr      <= '0;
        end else begin
            sendSync <= {sendSync[SYNC_STAGES-2:0], send};
            devBSync <= {devBSync[SYNC_STAGES-2:0], devB};
            state    <= stateNext;
            devA     <= stateNext == REQ;
            if (state == IDLE && selValid) begin
                grant <= NUM_REQ'(1) << selIdx;
                owner <= selIdx;
            end else if (stateNext == IDLE) begin
                grant <= '0;
            end
            if (state != IDLE && stateNext == IDLE) ptr <= ptrNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = selValid ? REQ : IDLE;
`ifdef HS_TIMEOUT_EN
            REQ:     stateNext = devBS ? REL : (timedOut ? RECOVER : REQ);
            REL:     stateNext = !devBS ? DONE : (timedOut ? RECOVER : REL);
            RECOVER: stateNext = devBS ? RECOVER : IDLE;
`else
            REQ:     stateNext = devBS ? REL : REQ;
            REL:     stateNext = devBS ? REL : DONE;
`endif
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy     = state != IDLE;
        done     = state == DONE ? grant : '0;
        LED_send = |sendS;
        LED_devB = devBS;
    end
endmodule
